// File: rtl/seg_scan_mux.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment bank.
// Inputs are shadowed once per frame; outputs are registered so anode and segments switch together.
module seg_scan_mux #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DIV_WIDTH    = 11,
    parameter int unsigned BRIGHT_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic                      lz_en,
    input  logic [BRIGHT_WIDTH-1:0]   brightness,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int unsigned IdxWidth = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IdxWidth-1:0] IdxLast = IdxWidth'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    presc_q;
    logic [IdxWidth-1:0]     idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] dig_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic                    lz_q;
    logic [BRIGHT_WIDTH-1:0] bright_q;

    logic                    slot_end;
    logic                    wrap;
    logic [BRIGHT_WIDTH-1:0] pwm_phase;
    logic                    pwm_on;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    lead_zero;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_supp;
    logic [6:0]              seg_d;
    logic                    dp_n_d;
    logic [NUM_DIGITS-1:0]   an_d;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        unique case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    always_comb begin
        slot_end = &presc_q;
        wrap     = slot_end && (idx_q == IdxLast);
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + IdxWidth'(1);
        end
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    always_comb begin
        supp      = '0;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead_zero = lead_zero & (dig_q[4*i +: 4] == 4'h0);
            supp[i]   = lz_q & lead_zero;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_supp  = 1'b0;
        pwm_phase = presc_q[DIV_WIDTH-1 -: BRIGHT_WIDTH];
        pwm_on    = (pwm_phase <= bright_q);
        an_d      = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxWidth'(i)) begin
                cur_nib   = dig_q[4*i +: 4];
                cur_dp    = dp_q[i];
                cur_blank = blank_q[i];
                cur_supp  = supp[i];
                an_d[i]   = ~pwm_on;
            end
        end
        seg_d  = (cur_blank || cur_supp) ? 7'h7F : ~decode(cur_nib);
        dp_n_d = cur_blank ? 1'b1 : ~cur_dp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            dig_q      <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            lz_q       <= 1'b0;
            bright_q   <= '0;
            seg        <= 7'h7F;
            dp_n       <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            presc_q    <= presc_q + DIV_WIDTH'(1);
            idx_q      <= idx_d;
            frame_tick <= wrap;
            if (wrap) begin
                dig_q    <= digits;
                dp_q     <= dp;
                blank_q  <= blank;
                lz_q     <= lz_en;
                bright_q <= brightness;
            end
            seg  <= seg_d;
            dp_n <= dp_n_d;
            an   <= an_d;
        end
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display bank. It scans NUM_DIGITS hex nibbles, with per-digit decimal point and blanking, leading-zero suppression and PWM brightness. Inputs are captured once per frame so the display never tears. It sits between the application datapath (score, counters, debug values) and the board display pins, and is the successor to the fixed 8-digit interface.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
DIV_WIDTH, 11, digit slot length = 2^DIV_WIDTH clk cycles
BRIGHT_WIDTH, 4, brightness resolution in bits (1..DIV_WIDTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
digits  in  4*NUM_DIGITS  packed hex digits; digit i = digits[4i+3:4i]; digit 0 is rightmost
dp  in  NUM_DIGITS  decimal point request per digit, active-high
blank  in  NUM_DIGITS  force digit i dark, active-high
lz_en  in  1  enable leading-zero suppression
brightness  in  BRIGHT_WIDTH  PWM duty code
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point, active-low
an  out  NUM_DIGITS  anode enables, active-low, one-hot-low when lit
frame_tick  out  1  one-cycle pulse at start of each frame

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: prescaler 0, index 0, shadow registers 0, an all ones, seg 7'h7F, dp_n 1, frame_tick 0. Reset mid-scan takes effect on the next clk edge and overrides all other activity.
- Prescaler: a DIV_WIDTH-bit free-running counter. slot_end is asserted when the counter is all ones.
- Index: 0..NUM_DIGITS-1, advanced on slot_end. It wraps from NUM_DIGITS-1 to 0 even when NUM_DIGITS is not a power of two. Index width is clog2(NUM_DIGITS).
- Frame capture: on the slot_end that wraps the index to 0, digits, dp, blank, lz_en and brightness are loaded into shadow registers. In the same cycle, frame_tick pulses high for exactly one cycle. Input changes at any other time have no effect until the next frame.
- First frame after reset: shadows hold 0 until the first wrap, so index 0 shows '0' at full brightness code 0 duty. The frame_tick pulse at the first wrap occurs 2^DIV_WIDTH*NUM_DIGITS cycles after reset release.
- Leading-zero suppression (shadow values): digit i>0 is suppressed when lz_en=1 and all shadow digits N-1..i equal 0. Digit 0 is never suppressed. Suppressed digits still show their dp if requested.
- Digit dark when shadow blank[i]=1. In that case seg=7F and dp_n=1, and the anode is still driven so scan timing is constant.
- PWM: pwm_phase = prescaler[DIV_WIDTH-1 : DIV_WIDTH-BRIGHT_WIDTH]. The current anode is low only while pwm_phase <= shadow brightness, giving duty (b+1)/2^BRIGHT_WIDTH. All ones means full on. Outside the on-window, an is all ones.
- Decode (active-high pattern before inversion, {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - seg = ~pattern, or 7F when the digit is suppressed or blank.
- Output registering: seg, dp_n and an are registered. They reflect the index/prescaler state with exactly 1 cycle latency. an changes on the same edge as seg, so there is no cross-digit ghosting.
- Simultaneous events: slot_end plus a frame wrap in the same cycle means the shadow load and the index change both happen on that edge. The new shadow values are used starting with digit 0 of the new frame.

Test Plan:
- Use DIV_WIDTH=4, BRIGHT_WIDTH=2, NUM_DIGITS=4 for all scenarios.
- Reset check: hold rst 3 cycles -> an=4'b1111, seg=7F, dp_n=1, frame_tick=0. After release, frame_tick first pulses 64 cycles later and every 64 cycles thereafter.
- Scan and decode: digits=16'h12AF, brightness=3, dp=4'b0100, frame captured -> per 16-cycle slot an=1110/1101/1011/0111 with seg=~71/~77/~5B/~06. dp_n=0 only during an=1011.
- Leading-zero suppression: digits=16'h0050, lz_en=1 -> digit3 seg=7F, digit2 seg=7F, digit1 seg=~6D, digit0 seg=~3F. With lz_en=0 all four show decoded values.
- PWM: brightness=1 -> anode low for 8 of 16 cycles per slot (pwm_phase 0,1). brightness=0 -> 4 of 16. Verify a brightness change mid-frame is not applied until after frame_tick.
- Tear-free capture and blanking: change digits mid-frame -> displayed values stay unchanged until the next frame. blank=4'b0010 -> digit1 seg=7F and dp_n=1 while its anode still cycles.
- Reset mid-scan: assert rst during index=2 -> next edge an=1111, index 0. On restart, the frame period is identical to the power-up case.
